frac_clk_gen: RTL and testbench

- Multi-channel fractional-N rate generator. Replaces the ad-hoc per-rate toggle dividers in the board tops (e.g. the serial 4x/1x clocks derived from the 24 MHz PLL clock).
- Each channel produces two outputs from one shared fabric clock: a single-cycle tick enable at an exact long-run average rate, and a 50%-duty square output.
- Rates are runtime-programmable, and a common sync input phase-aligns all channels.

---
 rtl/frac_clk_gen.sv | 81 ++++++++
 tb/tb_frac_clk_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/frac_clk_gen.sv
// Multi-channel fractional-N rate generator: per channel, a phase accumulator
// emits single-cycle ticks at an exact average rate plus a square output toggled per tick.
module frac_clk_gen #(
  parameter int                            CHANNELS    = 2,
  parameter int                            ACC_WIDTH   = 32,
  parameter longint unsigned               CLK_RATE    = 24000000,
  parameter logic [CHANNELS*ACC_WIDTH-1:0] RESET_RATES = {32'd300, 32'd1200},
  localparam int                           SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CHANNELS-1:0]  en,
  input  logic                 sync,
  input  logic                 wr_en,
  input  logic [SEL_W-1:0]     wr_sel,
  input  logic [ACC_WIDTH-1:0] wr_rate,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  sq
);

  localparam logic [ACC_WIDTH:0] CLK_W = (ACC_WIDTH+1)'(CLK_RATE);

  // Rates above the clock rate would break the acc < CLK_RATE invariant, so they
  // are limited on the way into the rate register.
  function automatic logic [ACC_WIDTH-1:0] clamp_rate(input logic [ACC_WIDTH-1:0] r);
    if ({1'b0, r} > CLK_W) begin
      return CLK_W[ACC_WIDTH-1:0];
    end
    return r;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [ACC_WIDTH-1:0] acc_d, acc_q;
    logic [ACC_WIDTH-1:0] rate_d, rate_q;
    logic                 tick_d, tick_q;
    logic                 sq_d, sq_q;
    logic [ACC_WIDTH:0]   sum;

    always_comb begin
      rate_d = rate_q;
      if (wr_en && (wr_sel == SEL_W'(i))) begin
        rate_d = clamp_rate(wr_rate);
      end

      sum    = {1'b0, acc_q} + {1'b0, rate_q};
      acc_d  = acc_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      if (sync) begin
        acc_d = '0;
        sq_d  = 1'b0;
      end else if (en[i]) begin
        if (sum >= CLK_W) begin
          acc_d  = ACC_WIDTH'(sum - CLK_W);
          tick_d = 1'b1;
          sq_d   = ~sq_q;
        end else begin
          acc_d = sum[ACC_WIDTH-1:0];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q  <= '0;
        rate_q <= clamp_rate(RESET_RATES[i*ACC_WIDTH +: ACC_WIDTH]);
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        acc_q  <= acc_d;
        rate_q <= rate_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule

// File: tb/tb_frac_clk_gen.sv
// Bench for frac_clk_gen: directed scenarios plus random traffic, checked every
// cycle against a cumulative-credit model (ticks = floor(total credit / CLK_RATE)).
module tb_frac_clk_gen;
  localparam int CH  = 3;
  localparam int AW  = 16;
  localparam int CLK = 24;
  localparam int SW  = 2;
  localparam int RST_R[CH] = '{7, 5, 40};

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH-1:0] en = '0;
  logic          sync = 1'b0;
  logic          wr_en = 1'b0;
  logic [SW-1:0] wr_sel = '0;
  logic [AW-1:0] wr_rate = '0;
  logic [CH-1:0] tick;
  logic [CH-1:0] sq;

  frac_clk_gen #(
    .CHANNELS   (CH),
    .ACC_WIDTH  (AW),
    .CLK_RATE   (CLK),
    .RESET_RATES({16'd40, 16'd5, 16'd7})
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .sync   (sync),
    .wr_en  (wr_en),
    .wr_sel (wr_sel),
    .wr_rate(wr_rate),
    .tick   (tick),
    .sq     (sq)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     passes = 0;
  int     fails  = 0;
  longint credit[CH];
  int     nticks[CH];
  int     rate_m[CH];
  bit     exp_tick[CH];
  bit     exp_sq[CH];
  int     tcnt[CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampr(input int r);
    return (r > CLK) ? CLK : r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      credit[i] = 0; nticks[i] = 0;
      rate_m[i] = clampr(RST_R[i]);
      exp_tick[i] = 0; exp_sq[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < CH; i++) begin
      if (sync) begin
        credit[i] = 0; nticks[i] = 0; exp_tick[i] = 0; exp_sq[i] = 0;
      end else if (en[i]) begin
        longint c2 = credit[i] + rate_m[i];
        exp_tick[i] = (c2 / CLK) > (credit[i] / CLK);
        if (exp_tick[i]) nticks[i]++;
        credit[i] = c2;
        exp_sq[i] = nticks[i][0];
      end else begin
        exp_tick[i] = 0;
      end
    end
    if (wr_en && int'(wr_sel) < CH) rate_m[wr_sel] = clampr(int'(wr_rate));
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < CH; i++) begin
        chk($sformatf("tick%0d", i), 32'(tick[i]), 32'(exp_tick[i]));
        chk($sformatf("sq%0d", i), 32'(sq[i]), 32'(exp_sq[i]));
        if (tick[i] === 1'b1) tcnt[i]++;
      end
      sync = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < CH; i++) tcnt[i] = 0;
  endtask

  task automatic wr(input int sel, input int rate);
    wr_en = 1'b1; wr_sel = SW'(sel); wr_rate = AW'(rate);
  endtask

  initial begin
    model_reset();
    clr_cnt();
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_sq", 32'(sq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = '1;

    // Reset rates: 7 Hz, 5 Hz and 40 Hz clamped to 24 Hz, over one full second.
    clr_cnt();
    step(24);
    chk("rst_rate0_cnt", 32'(tcnt[0]), 32'd7);
    chk("rst_rate1_cnt", 32'(tcnt[1]), 32'd5);
    chk("rst_rate2_clamp_cnt", 32'(tcnt[2]), 32'd24);

    // Rate 12 written together with sync: restart with the new rate.
    wr(0, 12); sync = 1'b1;
    step(1);
    clr_cnt();
    step(24);
    chk("rate12_cnt", 32'(tcnt[0]), 32'd12);

    // Rate 7 after sync: exactly 7 ticks in the window.
    wr(0, 7);
    step(5);
    sync = 1'b1;
    step(1);
    clr_cnt();
    step(24);
    chk("rate7_cnt", 32'(tcnt[0]), 32'd7);

    // Rate 0 silences ch0, then an oversized rate saturates to a tick every cycle.
    wr(0, 0);
    step(1);
    clr_cnt();
    step(10);
    chk("rate0_cnt", 32'(tcnt[0]), 32'd0);
    chk("rate0_ch1_cnt_nonzero", 32'(tcnt[1] > 0), 32'd1);
    wr(0, 1000);
    step(1);
    clr_cnt();
    step(6);
    chk("rate1000_cnt", 32'(tcnt[0]), 32'd6);

    // Sync pulse with ch1 disabled: ch1 silent, ch0 first tick after ceil(24/5)=5 edges.
    wr(0, 5);
    step(3);
    en = 3'b101;
    sync = 1'b1;
    step(1);
    clr_cnt();
    step(4);
    chk("sync_ch0_before_first", 32'(tcnt[0]), 32'd0);
    step(1);
    chk("sync_ch0_first_tick", 32'(tick[0]), 32'd1);
    step(10);
    chk("sync_ch1_silent", 32'(tcnt[1]), 32'd0);
    en = '1;
    step(7);

    // Out-of-range channel select is ignored.
    wr(3, 1);
    step(30);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) en = CH'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0)
        wr($urandom_range(0, 3), ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 30));
      if ($urandom_range(0, 40) == 0) sync = 1'b1;
      step(1);
    end

    // Async reset between edges while ch2 tick and sq are high.
    en = '1;
    wr(0, 12);
    step(1);
    wr(2, 24);
    step(2);
    for (int k = 0; k < 4 && !exp_sq[2]; k++) step(1);
    chk("pre_rst_tick2", 32'(tick[2]), 32'd1);
    chk("pre_rst_sq2", 32'(sq[2]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tick", 32'(tick), 32'd0);
    chk("async_rst_sq", 32'(sq), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clr_cnt();
    step(24);
    chk("revert_rate0_cnt", 32'(tcnt[0]), 32'd7);
    chk("revert_rate1_cnt", 32'(tcnt[1]), 32'd5);
    chk("revert_rate2_cnt", 32'(tcnt[2]), 32'd24);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
